// File: rtl/uart_rx_loopback_fifo.sv
// Receive-side loopback buffer: captures bytes from the UART receiver into a
// circular FIFO and hands them to the UART transmitter one frame at a time.
module uart_rx_loopback_fifo #(
  parameter int DEPTH        = 16,
  parameter int WIDTH        = 8,
  parameter int PTR_BITS     = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    rx_Data,
  input  logic                rx_Done,
  input  logic                tx_Busy,
  input  logic                clr_Overflow,
  output logic [WIDTH-1:0]    tx_Data,
  output logic                tx_Start,
  output logic                sig_Full,
  output logic                sig_Empty,
  output logic                overflow,
  output logic [PTR_BITS:0]   count
);

  localparam int TMR_BITS = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [PTR_BITS:0]   CNT_ONE  = (PTR_BITS+1)'(1);
  localparam logic [PTR_BITS:0]   CNT_ZERO = (PTR_BITS+1)'(0);
  localparam logic [PTR_BITS:0]   CNT_FULL = (PTR_BITS+1)'(DEPTH);
  localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);
  localparam logic [TMR_BITS-1:0] TMR_LOAD = TMR_BITS'(BUSY_TIMEOUT);
  localparam logic [TMR_BITS-1:0] TMR_ONE  = TMR_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS:0]    count_q, count_d;
  logic [TMR_BITS-1:0]  tmr_q, tmr_d;
  logic [WIDTH-1:0]     tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 ovf_q, ovf_d;
  logic                 rx_done_q;
  logic                 full_q, empty_q;
  logic                 push_req_s, push_ok_s, drop_s, pop_s;

  // Push/pop decisions and FIFO bookkeeping; full is the registered flag so a
  // push arriving while full is dropped even if the FSM pops in the same cycle.
  always_comb begin
    push_req_s = rx_Done & ~rx_done_q;
    push_ok_s  = push_req_s & ~full_q;
    drop_s     = push_req_s & full_q;
    pop_s      = (state_q == S_IDLE) & ~empty_q & ~tx_Busy;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_data_d  = tx_data_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      tx_data_d = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d  = rd_ptr_q;
      tx_data_d = tx_data_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_Overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Transmit handshake FSM: next state, busy-timeout counter and start pulse.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    tx_start_d = (state_q == S_START);
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        tmr_d   = TMR_LOAD;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_Busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
          // Transmitter missed the request; the byte is abandoned.
          if (tmr_q <= TMR_ONE) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_BUSY;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_Busy) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= CNT_ZERO;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ovf_q      <= 1'b0;
      rx_done_q  <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ovf_q      <= ovf_d;
      rx_done_q  <= rx_Done;
      full_q     <= (count_d == CNT_FULL);
      empty_q    <= (count_d == CNT_ZERO);
    end
  end

  // Storage array; contents are only ever read after being written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= rx_Data;
    end
  end

  assign tx_Data   = tx_data_q;
  assign tx_Start  = tx_start_q;
  assign sig_Full  = full_q;
  assign sig_Empty = empty_q;
  assign overflow  = ovf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_uart_rx_loopback_fifo.sv
// Self-checking bench for uart_rx_loopback_fifo with a behavioural transmitter
// model and a queue-based reference of the bytes that must be echoed.
module tb_uart_rx_loopback_fifo;

  localparam int DEPTH        = 16;
  localparam int BUSY_TIMEOUT = 4;

  logic       clk          = 1'b0;
  logic       reset        = 1'b0;
  logic [7:0] rx_Data      = 8'h00;
  logic       rx_Done      = 1'b0;
  logic       clr_Overflow = 1'b0;
  logic       force_busy   = 1'b0;
  logic       busy_model   = 1'b0;
  logic       tx_Busy;
  logic [7:0] tx_Data;
  logic       tx_Start, sig_Full, sig_Empty, overflow;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int frame_len = 10;
  bit tx_respond = 1'b1;
  logic [7:0] sent_q[$];
  int         start_cyc[$];
  logic [7:0] exp_q[$];

  assign tx_Busy = force_busy | busy_model;

  uart_rx_loopback_fifo #(.DEPTH(16), .WIDTH(8), .PTR_BITS(4), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .rx_Data(rx_Data), .rx_Done(rx_Done),
    .tx_Busy(tx_Busy), .clr_Overflow(clr_Overflow), .tx_Data(tx_Data),
    .tx_Start(tx_Start), .sig_Full(sig_Full), .sig_Empty(sig_Empty),
    .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter: latches tx_Data on each start request and stays busy for a frame.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (tx_Start === 1'b1) begin
        checks++;
        if (tx_Busy !== 1'b0) begin
          errors++;
          $display("FAIL start_while_busy: tx_Busy=%b required 0", tx_Busy);
        end
        sent_q.push_back(tx_Data);
        start_cyc.push_back(cyc);
        start_cnt++;
        if (tx_respond) begin
          busy_model = 1'b1;
          repeat (frame_len) @(posedge clk);
          #2;
          busy_model = 1'b0;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input int len);
    @(negedge clk);
    rx_Data = b;
    rx_Done = 1'b1;
    repeat (len) @(negedge clk);
    rx_Done = 1'b0;
  endtask

  task automatic wait_drain(input int n_sent, input string name);
    int t;
    t = 0;
    while (!(sent_q.size() >= n_sent && count == 5'd0 && tx_Busy == 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (8) @(negedge clk);
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL %s_drain_timeout: sent=%0d required %0d", name, sent_q.size(), n_sent);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_Data, tx_Start, sig_Full, sig_Empty, overflow, count} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h required %h",
               {tx_Data, tx_Start, sig_Full, sig_Empty, overflow, count}, {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int base;
    base = sent_q.size();
    @(negedge clk);
    rx_Data = 8'h5A;
    rx_Done = 1'b1;
    @(negedge clk);
    checks++;
    if (count !== 5'd1 || sig_Empty !== 1'b0 || tx_Start !== 1'b0) begin
      errors++;
      $display("FAIL single_push: count=%0d empty=%b start=%b required 1 0 0", count, sig_Empty, tx_Start);
    end
    @(negedge clk);
    checks++;
    if (count !== 5'd0 || tx_Data !== 8'h5A || tx_Start !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: count=%0d data=%h start=%b required 0 5a 0", count, tx_Data, tx_Start);
    end
    @(negedge clk);
    checks++;
    if (tx_Start !== 1'b1 || tx_Data !== 8'h5A) begin
      errors++;
      $display("FAIL single_start: start=%b data=%h required 1 5a", tx_Start, tx_Data);
    end
    rx_Done = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_Start !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_width: start=%b required 0", tx_Start);
    end
    wait_drain(base + 1, "single");
    checks++;
    if (sent_q.size() != base + 1 || sig_Empty !== 1'b1) begin
      errors++;
      $display("FAIL single_one_push: sent=%0d empty=%b required %0d 1", sent_q.size(), sig_Empty, base + 1);
    end else begin
      checks++;
      if (sent_q[base] !== 8'h5A) begin
        errors++;
        $display("FAIL single_data: got %h required 5a", sent_q[base]);
      end
    end
  endtask

  task automatic test_overflow;
    int base, s0;
    base = sent_q.size();
    s0 = start_cnt;
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1);
    @(negedge clk);
    checks++;
    if (count !== 5'd16 || sig_Full !== 1'b1 || overflow !== 1'b0 || start_cnt != s0) begin
      errors++;
      $display("FAIL ovf_fill: count=%0d full=%b ovf=%b starts=%0d required 16 1 0 %0d",
               count, sig_Full, overflow, start_cnt - s0, 0);
    end
    push_byte(8'hFF, 1);
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL ovf_drop: ovf=%b count=%0d required 1 16", overflow, count);
    end
    frame_len = 10;
    force_busy = 1'b0;
    wait_drain(base + DEPTH, "ovf");
    checks++;
    if (sent_q.size() != base + DEPTH) begin
      errors++;
      $display("FAIL ovf_sent_count: got %0d required %0d", sent_q.size() - base, DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (sent_q[base + i] !== 8'(i)) begin
          errors++;
          $display("FAIL ovf_order[%0d]: got %h required %h", i, sent_q[base + i], 8'(i));
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b required 1", overflow);
    end
    @(negedge clk);
    clr_Overflow = 1'b1;
    @(negedge clk);
    clr_Overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b required 0", overflow);
    end
  endtask

  task automatic test_simul;
    int base;
    logic [7:0] a, b;
    base = sent_q.size();
    a = 8'($urandom);
    b = 8'($urandom);
    force_busy = 1'b1;
    push_byte(a, 1);
    @(negedge clk);
    force_busy = 1'b0;
    rx_Data = b;
    rx_Done = 1'b1;
    @(negedge clk);
    rx_Done = 1'b0;
    checks++;
    if (count !== 5'd1 || tx_Data !== a) begin
      errors++;
      $display("FAIL simul_push_pop: count=%0d data=%h required 1 %h", count, tx_Data, a);
    end
    wait_drain(base + 2, "simul");
    checks++;
    if (sent_q.size() != base + 2) begin
      errors++;
      $display("FAIL simul_sent_count: got %0d required 2", sent_q.size() - base);
    end else if (sent_q[base] !== a || sent_q[base + 1] !== b) begin
      errors++;
      $display("FAIL simul_order: got %h %h required %h %h", sent_q[base], sent_q[base + 1], a, b);
    end
  endtask

  task automatic test_wrap;
    int base;
    logic [7:0] b;
    base = sent_q.size();
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      frame_len = $urandom_range(6, 10);
      b = 8'($urandom);
      exp_q.push_back(b);
      push_byte(b, $urandom_range(1, 3));
      repeat ($urandom_range(8, 16)) @(negedge clk);
    end
    wait_drain(base + exp_q.size(), "wrap");
    checks++;
    if (sent_q.size() != base + exp_q.size() || overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_count: sent=%0d ovf=%b required %0d 0", sent_q.size() - base, overflow, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (sent_q[base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL wrap_data[%0d]: got %h required %h", i, sent_q[base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_timeout;
    int base;
    logic [7:0] a, b;
    base = sent_q.size();
    a = 8'($urandom);
    b = 8'($urandom);
    tx_respond = 1'b0;
    force_busy = 1'b1;
    push_byte(a, 1);
    push_byte(b, 2);
    @(negedge clk);
    force_busy = 1'b0;
    wait_drain(base + 2, "timeout");
    checks++;
    if (sent_q.size() != base + 2) begin
      errors++;
      $display("FAIL timeout_starts: got %0d required 2", sent_q.size() - base);
    end else begin
      checks++;
      if (start_cyc[base + 1] - start_cyc[base] != BUSY_TIMEOUT + 2) begin
        errors++;
        $display("FAIL timeout_gap: got %0d required %0d", start_cyc[base + 1] - start_cyc[base], BUSY_TIMEOUT + 2);
      end
      checks++;
      if (sent_q[base] !== a || sent_q[base + 1] !== b) begin
        errors++;
        $display("FAIL timeout_order: got %h %h required %h %h", sent_q[base], sent_q[base + 1], a, b);
      end
    end
    tx_respond = 1'b1;
  endtask

  task automatic test_reset_mid;
    int s0, base;
    logic [7:0] b;
    frame_len = 40;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom), 1);
    @(negedge clk);
    checks++;
    if (count !== 5'd5 || tx_Busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup: count=%0d busy=%b required 5 1", count, tx_Busy);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({tx_Data, tx_Start, sig_Full, sig_Empty, overflow, count} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL rstmid_async: got %h required %h",
               {tx_Data, tx_Start, sig_Full, sig_Empty, overflow, count}, {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0});
    end
    s0 = start_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (start_cnt != s0 || count !== 5'd0 || sig_Empty !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_quiet: starts=%0d count=%0d empty=%b required 0 0 1", start_cnt - s0, count, sig_Empty);
    end
    frame_len = 10;
    b = 8'($urandom);
    base = sent_q.size();
    push_byte(b, 1);
    wait_drain(base + 1, "rstmid");
    checks++;
    if (sent_q.size() != base + 1) begin
      errors++;
      $display("FAIL rstmid_resume: sent=%0d required 1", sent_q.size() - base);
    end else if (sent_q[base] !== b) begin
      errors++;
      $display("FAIL rstmid_data: got %h required %h", sent_q[base], b);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_simul();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
